// File: rtl/hsiao_secded_dec_pipe.sv
// rtl/hsiao_secded_dec_pipe.sv - two-stage Hsiao SECDED decoder with error counters and first-fatal capture
module hsiao_secded_dec_pipe #(
  parameter int K     = 64,
  parameter int R     = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     i_valid,
  input  logic [K+R-1:0]           i_code,
  input  logic                     i_cnt_clr,
  output logic [K-1:0]             o_data,
  output logic                     o_valid,
  output logic                     o_err_detec,
  output logic                     o_err_corr,
  output logic                     o_err_fatal,
  output logic [R-1:0]             o_syndrome,
  output logic [$clog2(K+R)-1:0]   o_err_pos,
  output logic [CNT_W-1:0]         o_corr_cnt,
  output logic [CNT_W-1:0]         o_fatal_cnt,
  output logic [R-1:0]             o_first_fatal_syn
);

  localparam int N  = K + R;
  localparam int PW = $clog2(N);

  // Column i of H lives at H_TAB[i*R +: R]: weight-3 then weight-5 data columns, unit check columns.
  function automatic logic [N*R-1:0] build_h();
    logic [N*R-1:0] tab;
    int n;
    tab = '0;
    n   = 0;
    for (int w = 3; w <= 5; w += 2) begin
      for (int v = 0; v < (1 << R); v++) begin
        if ($countones(v) == w && n < K) begin
          tab[n*R +: R] = R'(v);
          n++;
        end
      end
    end
    for (int j = 0; j < R; j++) tab[(K+j)*R +: R] = R'(1 << j);
    return tab;
  endfunction

  localparam logic [N*R-1:0] H_TAB = build_h();

  logic [N-1:0]     s1_code_q, s1_code_d;
  logic             s1_valid_q, s1_valid_d;
  logic [R-1:0]     s1_syn_q, s1_syn_d;

  logic [K-1:0]     data_q, data_d;
  logic             valid_q, valid_d;
  logic             detec_q, detec_d;
  logic             corr_q, corr_d;
  logic             fatal_q, fatal_d;
  logic [R-1:0]     syn_q, syn_d;
  logic [PW-1:0]    pos_q, pos_d;
  logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0] fatal_cnt_q, fatal_cnt_d;
  logic [R-1:0]     first_syn_q, first_syn_d;

  logic [R-1:0]     in_syn;
  logic             hit;
  logic             data_hit;
  logic [PW-1:0]    hit_pos;
  logic [K-1:0]     fixed_data;

  always_comb begin
    in_syn = '0;
    for (int i = 0; i < N; i++) begin
      if (i_code[i]) in_syn = in_syn ^ H_TAB[i*R +: R];
    end
  end

  always_comb begin
    hit      = 1'b0;
    data_hit = 1'b0;
    hit_pos  = '0;
    for (int i = 0; i < N; i++) begin
      if (s1_syn_q == H_TAB[i*R +: R]) begin
        hit     = 1'b1;
        hit_pos = PW'(i);
        if (i < K) data_hit = 1'b1;
      end
    end
    fixed_data = s1_code_q[K-1:0] ^ (data_hit ? (K'(1) << hit_pos) : '0);
  end

  always_comb begin
    s1_code_d   = s1_code_q;
    s1_valid_d  = s1_valid_q;
    s1_syn_d    = s1_syn_q;
    data_d      = data_q;
    valid_d     = valid_q;
    detec_d     = detec_q;
    corr_d      = corr_q;
    fatal_d     = fatal_q;
    syn_d       = syn_q;
    pos_d       = pos_q;
    corr_cnt_d  = corr_cnt_q;
    fatal_cnt_d = fatal_cnt_q;
    first_syn_d = first_syn_q;

    if (enable) begin
      s1_code_d  = i_code;
      s1_valid_d = i_valid;
      s1_syn_d   = in_syn;

      // Bubble slots present all-zero outputs.
      valid_d = s1_valid_q;
      data_d  = s1_valid_q ? fixed_data : '0;
      syn_d   = s1_valid_q ? s1_syn_q : '0;
      detec_d = s1_valid_q && (s1_syn_q != '0);
      corr_d  = s1_valid_q && hit;
      fatal_d = s1_valid_q && (s1_syn_q != '0) && !hit;
      pos_d   = (s1_valid_q && hit) ? hit_pos : '0;

      // Clear wins over any word leaving the pipe in the same cycle.
      if (i_cnt_clr) begin
        corr_cnt_d  = '0;
        fatal_cnt_d = '0;
        first_syn_d = '0;
      end else begin
        if (corr_d && corr_cnt_q != '1)   corr_cnt_d  = corr_cnt_q + 1'b1;
        if (fatal_d && fatal_cnt_q != '1) fatal_cnt_d = fatal_cnt_q + 1'b1;
        // A fatal syndrome is never zero, so zero means nothing captured yet.
        if (fatal_d && first_syn_q == '0) first_syn_d = s1_syn_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_code_q   <= '0;
      s1_valid_q  <= 1'b0;
      s1_syn_q    <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      detec_q     <= 1'b0;
      corr_q      <= 1'b0;
      fatal_q     <= 1'b0;
      syn_q       <= '0;
      pos_q       <= '0;
      corr_cnt_q  <= '0;
      fatal_cnt_q <= '0;
      first_syn_q <= '0;
    end else begin
      s1_code_q   <= s1_code_d;
      s1_valid_q  <= s1_valid_d;
      s1_syn_q    <= s1_syn_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      detec_q     <= detec_d;
      corr_q      <= corr_d;
      fatal_q     <= fatal_d;
      syn_q       <= syn_d;
      pos_q       <= pos_d;
      corr_cnt_q  <= corr_cnt_d;
      fatal_cnt_q <= fatal_cnt_d;
      first_syn_q <= first_syn_d;
    end
  end

  assign o_data            = data_q;
  assign o_valid           = valid_q;
  assign o_err_detec       = detec_q;
  assign o_err_corr        = corr_q;
  assign o_err_fatal       = fatal_q;
  assign o_syndrome        = syn_q;
  assign o_err_pos         = pos_q;
  assign o_corr_cnt        = corr_cnt_q;
  assign o_fatal_cnt       = fatal_cnt_q;
  assign o_first_fatal_syn = first_syn_q;

endmodule

// File: tb/tb_hsiao_secded_dec_pipe.sv
// tb/tb_hsiao_secded_dec_pipe.sv - randomized bench for hsiao_secded_dec_pipe against a behavioural decoder model
module tb_hsiao_secded_dec_pipe;
  localparam int K = 64;
  localparam int R = 8;
  localparam int N = K + R;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          i_valid = 1'b0;
  logic [N-1:0]  i_code = '0;
  logic          i_cnt_clr = 1'b0;

  logic [K-1:0]  o_data, o_data2;
  logic          o_valid, o_valid2;
  logic          o_err_detec, o_err_detec2;
  logic          o_err_corr, o_err_corr2;
  logic          o_err_fatal, o_err_fatal2;
  logic [R-1:0]  o_syndrome, o_syndrome2;
  logic [6:0]    o_err_pos, o_err_pos2;
  logic [15:0]   o_corr_cnt, o_fatal_cnt;
  logic [1:0]    o_corr_cnt2, o_fatal_cnt2;
  logic [R-1:0]  o_first_fatal_syn, o_first_fatal_syn2;

  always #5 clk = ~clk;

  hsiao_secded_dec_pipe #(.K(K), .R(R), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .i_valid(i_valid), .i_code(i_code),
    .i_cnt_clr(i_cnt_clr), .o_data(o_data), .o_valid(o_valid), .o_err_detec(o_err_detec),
    .o_err_corr(o_err_corr), .o_err_fatal(o_err_fatal), .o_syndrome(o_syndrome),
    .o_err_pos(o_err_pos), .o_corr_cnt(o_corr_cnt), .o_fatal_cnt(o_fatal_cnt),
    .o_first_fatal_syn(o_first_fatal_syn)
  );

  hsiao_secded_dec_pipe #(.K(K), .R(R), .CNT_W(2)) dut_sat (
    .clk(clk), .reset_n(reset_n), .enable(enable), .i_valid(i_valid), .i_code(i_code),
    .i_cnt_clr(i_cnt_clr), .o_data(o_data2), .o_valid(o_valid2), .o_err_detec(o_err_detec2),
    .o_err_corr(o_err_corr2), .o_err_fatal(o_err_fatal2), .o_syndrome(o_syndrome2),
    .o_err_pos(o_err_pos2), .o_corr_cnt(o_corr_cnt2), .o_fatal_cnt(o_fatal_cnt2),
    .o_first_fatal_syn(o_first_fatal_syn2)
  );

  int           n_vec = 0;
  int           n_err = 0;
  logic [R-1:0] hcol [N];

  // Reference state: one word waiting between the two enabled edges, plus expected outputs.
  logic         m_valid;
  logic [N-1:0] m_code;
  logic         e_valid, e_det, e_corr, e_fatal, e_first_seen;
  logic [K-1:0] e_data;
  logic [R-1:0] e_syn, e_first;
  int           e_pos, e_ccnt, e_fcnt, e_ccnt2, e_fcnt2;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void decode(input logic [N-1:0] c, output logic [R-1:0] syn, output int idx);
    syn = '0;
    for (int i = 0; i < N; i++) if (c[i]) syn = syn ^ hcol[i];
    idx = -1;
    for (int i = 0; i < N; i++) if (syn == hcol[i]) idx = i;
  endfunction

  function automatic logic [N-1:0] gen_code();
    logic [N-1:0] c;
    logic [R-1:0] chk;
    int           idx;
    c = {8'h00, $urandom, $urandom};
    decode(c, chk, idx);
    c[N-1:K] = chk;
    for (int f = $urandom_range(0, 3); f > 0; f--) c[$urandom_range(0, N-1)] ^= 1'b1;
    return c;
  endfunction

  task automatic model_step();
    logic [R-1:0] syn;
    int           idx;
    if (!reset_n) begin
      m_valid = 0; m_code = '0;
      e_valid = 0; e_det = 0; e_corr = 0; e_fatal = 0; e_data = '0; e_syn = '0; e_pos = 0;
      e_ccnt = 0; e_fcnt = 0; e_ccnt2 = 0; e_fcnt2 = 0; e_first = '0; e_first_seen = 0;
    end else if (enable) begin
      e_valid = m_valid;
      e_det = 0; e_corr = 0; e_fatal = 0; e_data = '0; e_syn = '0; e_pos = 0;
      if (m_valid) begin
        decode(m_code, syn, idx);
        e_syn   = syn;
        e_det   = (syn != 0);
        e_corr  = (idx >= 0);
        e_fatal = (syn != 0) && (idx < 0);
        e_pos   = (idx >= 0) ? idx : 0;
        e_data  = m_code[K-1:0];
        if (idx >= 0 && idx < K) e_data[idx] = ~e_data[idx];
      end
      if (i_cnt_clr) begin
        e_ccnt = 0; e_fcnt = 0; e_ccnt2 = 0; e_fcnt2 = 0; e_first = '0; e_first_seen = 0;
      end else begin
        if (e_corr) begin
          e_ccnt  = (e_ccnt < 65535) ? e_ccnt + 1 : e_ccnt;
          e_ccnt2 = (e_ccnt2 < 3) ? e_ccnt2 + 1 : e_ccnt2;
        end
        if (e_fatal) begin
          e_fcnt  = (e_fcnt < 65535) ? e_fcnt + 1 : e_fcnt;
          e_fcnt2 = (e_fcnt2 < 3) ? e_fcnt2 + 1 : e_fcnt2;
          if (!e_first_seen) begin e_first = e_syn; e_first_seen = 1; end
        end
      end
      m_valid = i_valid;
      m_code  = i_code;
    end
  endtask

  task automatic compare_all();
    cmp("o_valid", 64'(o_valid), 64'(e_valid));
    cmp("o_err_detec", 64'(o_err_detec), 64'(e_det));
    cmp("o_err_corr", 64'(o_err_corr), 64'(e_corr));
    cmp("o_err_fatal", 64'(o_err_fatal), 64'(e_fatal));
    if (e_valid) begin
      cmp("o_data", o_data, e_data);
      cmp("o_syndrome", 64'(o_syndrome), 64'(e_syn));
      cmp("o_err_pos", 64'(o_err_pos), 64'(e_pos));
    end
    cmp("o_corr_cnt", 64'(o_corr_cnt), 64'(e_ccnt));
    cmp("o_fatal_cnt", 64'(o_fatal_cnt), 64'(e_fcnt));
    cmp("o_first_fatal_syn", 64'(o_first_fatal_syn), 64'(e_first));
    cmp("sat_corr_cnt", 64'(o_corr_cnt2), 64'(e_ccnt2));
    cmp("sat_fatal_cnt", 64'(o_fatal_cnt2), 64'(e_fcnt2));
  endtask

  // Called just after a falling edge: drive, predict the next rising edge, then check.
  task automatic tick(input logic rn, input logic en, input logic v, input logic clr,
                      input logic [N-1:0] code);
    reset_n = rn; enable = en; i_valid = v; i_cnt_clr = clr; i_code = code;
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int n;
    n = 0;
    for (int w = 3; w <= 5; w += 2)
      for (int v = 0; v < 256; v++)
        if ($countones(v) == w && n < K) begin hcol[n] = 8'(v); n++; end
    for (int j = 0; j < R; j++) hcol[K+j] = 8'(1 << j);

    @(negedge clk);
    tick(0, 0, 1, 0, '1);
    cmp("reset o_valid", 64'(o_valid), 0);
    cmp("reset o_data", o_data, 0);
    cmp("reset o_err_pos", 64'(o_err_pos), 0);
    cmp("reset o_corr_cnt", 64'(o_corr_cnt), 0);

    tick(1, 1, 1, 0, 72'h0);
    tick(1, 1, 1, 0, 72'h1);
    cmp("clean o_valid", 64'(o_valid), 1);
    cmp("clean o_syndrome", 64'(o_syndrome), 0);
    tick(1, 1, 1, 0, 72'h3);
    cmp("bit0 o_syndrome", 64'(o_syndrome), 64'h07);
    cmp("bit0 o_err_corr", 64'(o_err_corr), 1);
    cmp("bit0 o_err_pos", 64'(o_err_pos), 0);
    cmp("bit0 o_corr_cnt", 64'(o_corr_cnt), 1);
    tick(1, 1, 1, 0, 72'h10000000000000000);
    cmp("bits01 o_syndrome", 64'(o_syndrome), 64'h0C);
    cmp("bits01 o_err_fatal", 64'(o_err_fatal), 1);
    cmp("bits01 o_data", o_data, 64'h3);
    cmp("bits01 o_first_fatal_syn", 64'(o_first_fatal_syn), 64'h0C);
    tick(1, 1, 1, 0, 72'hF80000000000000000);
    cmp("bit64 o_syndrome", 64'(o_syndrome), 64'h01);
    cmp("bit64 o_err_pos", 64'(o_err_pos), 64);
    cmp("bit64 o_data", o_data, 0);
    tick(1, 1, 0, 0, 72'h0);
    cmp("chk5 o_syndrome", 64'(o_syndrome), 64'hF8);
    cmp("chk5 o_err_fatal", 64'(o_err_fatal), 1);
    cmp("chk5 o_fatal_cnt", 64'(o_fatal_cnt), 2);

    for (int i = 0; i < 3; i++) tick(1, 1, 1, 0, 72'h1);
    tick(1, 1, 0, 0, 72'h0);
    tick(1, 1, 0, 0, 72'h0);
    cmp("saturated corr_cnt", 64'(o_corr_cnt2), 3);
    cmp("unsaturated corr_cnt", 64'(o_corr_cnt), 5);
    tick(1, 1, 1, 1, 72'h3);
    tick(1, 1, 0, 1, 72'h0);
    cmp("clear wins fatal_cnt", 64'(o_fatal_cnt), 0);
    cmp("clear wins first_syn", 64'(o_first_fatal_syn), 0);

    // Four-word stream with a three-cycle stall in the middle.
    tick(1, 1, 1, 0, gen_code());
    tick(1, 1, 1, 0, gen_code());
    for (int i = 0; i < 3; i++) tick(1, 0, 1, 0, gen_code());
    tick(1, 1, 1, 0, gen_code());
    tick(1, 1, 1, 0, gen_code());
    for (int i = 0; i < 3; i++) tick(1, 1, 0, 0, 72'h0);

    // Reset with two words in flight.
    tick(1, 1, 1, 0, 72'h1);
    tick(1, 1, 1, 0, 72'h3);
    tick(0, 1, 0, 0, 72'h0);
    cmp("midreset o_valid", 64'(o_valid), 0);
    cmp("midreset o_corr_cnt", 64'(o_corr_cnt), 0);
    tick(1, 1, 0, 0, 72'h0);
    tick(1, 1, 1, 0, 72'h1);
    tick(1, 1, 0, 0, 72'h0);
    cmp("post-reset latency o_valid", 64'(o_valid), 1);

    for (int i = 0; i < 2500; i++)
      tick($urandom_range(0, 199) != 0, $urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7,
           $urandom_range(0, 49) == 0, gen_code());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
